// File: rtl/hwag_pkg.sv
// Shared types and defaults for the missing-tooth gap synchroniser.
// Pure declarations: no logic, no latency, no flow control.
package hwag_pkg;

  localparam int HWAG_PCAP_W = 24;
  localparam int HWAG_TEETH  = 58;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEARCH,
    ST_CHECK,
    ST_SYNC
  } hwag_state_t;

endpackage

// File: rtl/hwag_gap_sync_if.sv
// Capture strobes in, lock status and event pulses out.
// Strobe-based: no backpressure, the synchroniser accepts every capture.
interface hwag_gap_sync_if
  import hwag_pkg::*;
#(
  parameter int WIDTH = HWAG_PCAP_W
);
  logic             cap_valid;
  logic [WIDTH-1:0] pcap0;
  logic [WIDTH-1:0] pcap1;
  logic             ovf;
  logic             sync;
  logic [5:0]       tooth_cnt;
  logic [15:0]      rev_cnt;
  logic             gap_pulse;
  logic             err_pulse;

  modport master (
    output cap_valid, pcap0, pcap1, ovf,
    input  sync, tooth_cnt, rev_cnt, gap_pulse, err_pulse
  );

  modport slave (
    input  cap_valid, pcap0, pcap1, ovf,
    output sync, tooth_cnt, rev_cnt, gap_pulse, err_pulse
  );
endinterface

// File: rtl/hwag_gap_cmp.sv
// Gap test: newest period exceeds 1.5x the previous one; combinational, 0 cycles.
// One extra bit of headroom keeps the threshold from wrapping at full-scale periods.
module hwag_gap_cmp
  import hwag_pkg::*;
#(
  parameter int WIDTH = HWAG_PCAP_W
) (
  input  logic [WIDTH-1:0] pcap0,
  input  logic [WIDTH-1:0] pcap1,
  output logic             gap
);

  logic [WIDTH:0] thr;

  assign thr = {1'b0, pcap1} + {2'b00, pcap1[WIDTH-1:1]};
  assign gap = ({1'b0, pcap0} > thr);

endmodule

// File: rtl/hwag_gap_sync.sv
// Locks onto a missing-tooth wheel, tracks tooth index and revolutions.
// Outputs registered, 1 cycle after the capture strobe; no backpressure.
module hwag_gap_sync
  import hwag_pkg::*;
#(
  parameter int WIDTH = HWAG_PCAP_W,
  parameter int TEETH = HWAG_TEETH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  hwag_gap_sync_if.slave  bus
);

  localparam logic [5:0] LAST_TOOTH = 6'(TEETH - 1);

  hwag_state_t state;
  logic        fill_q;
  logic        sync_q;
  logic [5:0]  tooth_q;
  logic [15:0] rev_q;
  logic        gap_q;
  logic        err_q;
  logic        gap;

  hwag_gap_cmp #(.WIDTH(WIDTH)) u_cmp (
    .pcap0 (bus.pcap0),
    .pcap1 (bus.pcap1),
    .gap   (gap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      fill_q  <= 1'b0;
      sync_q  <= 1'b0;
      tooth_q <= '0;
      rev_q   <= '0;
      gap_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      gap_q <= 1'b0;
      err_q <= 1'b0;
      if (!ena) begin
        state   <= ST_IDLE;
        fill_q  <= 1'b0;
        sync_q  <= 1'b0;
        tooth_q <= '0;
        rev_q   <= '0;
      end else if (state == ST_IDLE) begin
        state  <= ST_FILL;
        fill_q <= 1'b0;
      end else if (bus.ovf) begin
        // Wheel stopped: relearn from scratch, but keep the revolution tally.
        state   <= ST_FILL;
        fill_q  <= 1'b0;
        tooth_q <= '0;
        sync_q  <= 1'b0;
        err_q   <= (state == ST_SYNC);
      end else if (bus.cap_valid) begin
        case (state)
          ST_FILL: begin
            if (fill_q) begin
              state  <= ST_SEARCH;
              fill_q <= 1'b0;
            end else begin
              fill_q <= 1'b1;
            end
          end
          ST_SEARCH: begin
            if (gap) begin
              state   <= ST_CHECK;
              tooth_q <= '0;
              gap_q   <= 1'b1;
            end
          end
          ST_CHECK, ST_SYNC: begin
            if (gap) begin
              tooth_q <= '0;
              gap_q   <= 1'b1;
              if (tooth_q == LAST_TOOTH) begin
                state  <= ST_SYNC;
                sync_q <= 1'b1;
                if (state == ST_SYNC) rev_q <= rev_q + 16'd1;
              end else begin
                state  <= ST_CHECK;
                sync_q <= 1'b0;
                err_q  <= 1'b1;
              end
            end else begin
              // Counter may step to TEETH on a missing gap; SEARCH then holds it.
              tooth_q <= tooth_q + 6'd1;
              if (tooth_q == LAST_TOOTH) begin
                state  <= ST_SEARCH;
                sync_q <= 1'b0;
                err_q  <= 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sync      = sync_q;
  assign bus.tooth_cnt = tooth_q;
  assign bus.rev_cnt   = rev_q;
  assign bus.gap_pulse = gap_q;
  assign bus.err_pulse = err_q;

endmodule

// File: tb/tb_hwag_gap_sync.sv
// Directed lock/error/threshold scenarios plus random traffic, checked against
// a behavioural model of the wheel-sync rules.
module tb_hwag_gap_sync;
  import hwag_pkg::*;

  localparam int W = HWAG_PCAP_W;
  localparam int T = HWAG_TEETH;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  int   errors = 0;
  int   checks = 0;

  hwag_gap_sync_if #(.WIDTH(W)) ifc ();

  hwag_gap_sync #(.WIDTH(W), .TEETH(T)) dut (
    .clk (clk),
    .rst (rst_n),
    .ena (ena),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  // Model: running, captures seen since restart, gap reference held, locked.
  bit         m_run, m_ref, m_lock, e_gap, e_err;
  int         m_prime, m_tooth, m_rev;
  logic [W-1:0] prev;

  task automatic model_clear();
    m_run = 0; m_ref = 0; m_lock = 0; m_prime = 0; m_tooth = 0; m_rev = 0;
    e_gap = 0; e_err = 0;
  endtask

  task automatic model(input bit e, input bit cv, input bit o,
                       input logic [W-1:0] p0, input logic [W-1:0] p1);
    bit g;
    e_gap = 0; e_err = 0;
    g = longint'(p0) > longint'(p1) + longint'(p1) / 2;
    if (!e) begin
      model_clear();
    end else if (!m_run) begin
      m_run = 1; m_prime = 0;
    end else if (o) begin
      e_err = m_lock; m_prime = 0; m_ref = 0; m_lock = 0; m_tooth = 0;
    end else if (cv) begin
      if (m_prime < 2) begin
        m_prime++;
      end else if (!m_ref) begin
        if (g) begin m_ref = 1; m_tooth = 0; e_gap = 1; end
      end else if (g) begin
        e_gap = 1;
        if (m_tooth == T - 1) begin
          if (m_lock) m_rev = (m_rev + 1) % 65536;
          m_lock = 1;
        end else begin
          e_err = 1; m_lock = 0;
        end
        m_tooth = 0;
      end else begin
        if (m_tooth == T - 1) begin e_err = 1; m_lock = 0; m_ref = 0; end
        m_tooth++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".sync"},  32'(ifc.sync),      32'(m_lock));
    chk({tag, ".tooth"}, 32'(ifc.tooth_cnt), 32'(m_tooth));
    chk({tag, ".rev"},   32'(ifc.rev_cnt),   32'(m_rev));
    chk({tag, ".gap"},   32'(ifc.gap_pulse), 32'(e_gap));
    chk({tag, ".err"},   32'(ifc.err_pulse), 32'(e_err));
  endtask

  task automatic step(input string tag, input bit e, input bit cv, input bit o,
                      input logic [W-1:0] p0, input logic [W-1:0] p1);
    @(negedge clk);
    ena = e; ifc.cap_valid = cv; ifc.ovf = o; ifc.pcap0 = p0; ifc.pcap1 = p1;
    model(e, cv, o, p0, p1);
    @(posedge clk);
    #1;
    chk_all(tag);
    ifc.cap_valid = 1'b0; ifc.ovf = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b1, 1'b0, 1'b0, prev, prev);
  endtask

  task automatic tooth(input string tag, input logic [W-1:0] p);
    if ($urandom_range(0, 3) == 0) idle(tag, int'($urandom_range(1, 2)));
    step(tag, 1'b1, 1'b1, 1'b0, p, prev);
    prev = p;
  endtask

  function automatic logic [W-1:0] norm();
    return W'(950 + $urandom_range(0, 100));
  endfunction

  task automatic teeth(input string tag, input int n);
    for (int i = 0; i < n; i++) tooth(tag, norm());
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0;
    ifc.cap_valid = 1'b0; ifc.ovf = 1'b0; ifc.pcap0 = '0; ifc.pcap1 = '0;
    prev = W'(1000);
    model_clear();
    #12;
    chk_all("reset");
    @(negedge clk); rst_n = 1'b1;
    step("post_rst", 1'b0, 1'b1, 1'b0, W'(3000), W'(1000));

    // Lock: fill, search, two revolutions, third gap counts one revolution.
    step("enable", 1'b1, 1'b0, 1'b0, prev, prev);
    teeth("lock_fill", 60);
    tooth("gap1", W'(3000));
    teeth("rev1", T - 1);
    tooth("gap2", W'(3000));
    chk("lock_sync", 32'(ifc.sync), 32'd1);
    teeth("rev2", T - 1);
    chk("tooth_57", 32'(ifc.tooth_cnt), 32'd57);
    tooth("gap3", W'(3000));
    chk("rev_one", 32'(ifc.rev_cnt), 32'd1);

    // Early gap at tooth 30, then recovery.
    teeth("pre_early", 30);
    tooth("early", W'(3000));
    chk("early_err", 32'(ifc.err_pulse), 32'd1);
    teeth("recover", T - 1);
    tooth("recover_gap", W'(3000));
    chk("recover_sync", 32'(ifc.sync), 32'd1);

    // Missing gap: a normal tooth where the gap belongs.
    teeth("pre_miss", T - 1);
    tooth("miss", W'(1000));
    chk("miss_sync", 32'(ifc.sync), 32'd0);

    // Threshold boundary from SEARCH, then full-scale with no wrap.
    step("thr_1500", 1'b1, 1'b1, 1'b0, W'(1500), W'(1000));
    step("thr_1501", 1'b1, 1'b1, 1'b0, W'(1501), W'(1000));
    chk("thr_gap", 32'(ifc.gap_pulse), 32'd1);
    step("thr_ovf", 1'b1, 1'b0, 1'b1, prev, prev);
    teeth("thr_fill", 2);
    step("thr_full", 1'b1, 1'b1, 1'b0, W'(24'hFFFFFF), W'(24'hFFFFFF));

    // Relock, then overflow coincident with a gap capture.
    prev = W'(1000);
    tooth("ovf_gap1", W'(3000));
    teeth("ovf_rev", T - 1);
    tooth("ovf_gap2", W'(3000));
    step("ovf_cv", 1'b1, 1'b1, 1'b1, W'(3000), W'(1000));
    chk("ovf_err", 32'(ifc.err_pulse), 32'd1);

    // Revolution counter wrap via preload.
    teeth("wrap_fill", 3);
    tooth("wrap_g1", W'(3000));
    teeth("wrap_r1", T - 1);
    tooth("wrap_g2", W'(3000));
    @(negedge clk);
    force dut.rev_q = 16'hFFFF;
    #1 release dut.rev_q;
    m_rev = 65535;
    teeth("wrap_r2", T - 1);
    tooth("wrap_g3", W'(3000));
    chk("wrap_zero", 32'(ifc.rev_cnt), 32'd0);

    // ena low beats a coincident capture.
    step("ena_off", 1'b0, 1'b1, 1'b0, W'(3000), W'(1000));
    chk("ena_off_tooth", 32'(ifc.tooth_cnt), 32'd0);

    // Mid-revolution asynchronous reset.
    step("rst_en", 1'b1, 1'b0, 1'b0, prev, prev);
    teeth("rst_fill", 3);
    tooth("rst_g1", W'(3000));
    teeth("rst_r1", T - 1);
    tooth("rst_g2", W'(3000));
    teeth("rst_mid", 10);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk_all("async_rst");
    @(negedge clk); rst_n = 1'b1;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      bit e, cv, o;
      logic [W-1:0] p0, p1;
      int k;
      e  = ($urandom_range(0, 199) != 0);
      o  = ($urandom_range(0, 149) == 0);
      cv = ($urandom_range(0, 2) != 0);
      k  = int'($urandom_range(0, 59));
      p1 = ($urandom_range(0, 19) == 0) ? W'($urandom) : prev;
      if (k == 0)      p0 = W'($urandom);
      else if (k == 1) p0 = p1 + (p1 >> 1) + W'($urandom_range(0, 1));
      else if (k < 5)  p0 = W'(3000);
      else             p0 = norm();
      step("rand", e, cv, o, p0, p1);
      if (cv) prev = p0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hwag_gap_sync.md
HWAG_GAP_SYNC -- requirements
Module: hwag_gap_sync

Interface
REQ-001 Parameter WIDTH, default 24: period capture width in bits.
REQ-002 Parameter TEETH, default 58: physical teeth per revolution (60-2 wheel); TEETH SHALL be in 3..63.
REQ-003 Port clk, input, 1: sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-low.
REQ-005 Port ena, input, 1: block enable (global control bit 0).
REQ-006 Port cap_valid, input, 1: one-cycle strobe; pcap0/pcap1 hold a new capture this cycle.
REQ-007 Port pcap0, input, WIDTH: newest tooth period.
REQ-008 Port pcap1, input, WIDTH: previous tooth period.
REQ-009 Port ovf, input, 1: period counter overflow strobe (wheel stopped).
REQ-010 Port sync, output, 1: high while locked to the wheel.
REQ-011 Port tooth_cnt, output, 6: tooth index since last gap, 0 = first tooth after gap.
REQ-012 Port rev_cnt, output, 16: revolutions completed while in SYNC.
REQ-013 Port gap_pulse, output, 1: one-cycle strobe on each qualified gap.
REQ-014 Port err_pulse, output, 1: one-cycle strobe on each sync error.

Function
REQ-015 States SHALL be IDLE, FILL, SEARCH, CHECK, SYNC; all transitions occur only on cap_valid, ovf or ena.
REQ-016 ena low SHALL force IDLE next cycle and clear sync, tooth_cnt, rev_cnt, fill count; pulses low.
REQ-017 IDLE -> FILL when ena high.
REQ-018 FILL SHALL count cap_valid strobes; on the 2nd strobe -> SEARCH (pcap1 then valid).
REQ-019 Gap criterion, per cap_valid: gap = (pcap0 > pcap1 + (pcap1 >> 1)), computed at WIDTH+1 bits, no overflow.
REQ-020 SEARCH: gap -> CHECK, tooth_cnt <= 0, gap_pulse; non-gap -> stay, tooth_cnt unchanged.
REQ-021 CHECK/SYNC, non-gap: tooth_cnt <= tooth_cnt + 1; if tooth_cnt was already TEETH-1 -> SEARCH, err_pulse, sync low (missing gap).
REQ-022 CHECK/SYNC, gap with tooth_cnt == TEETH-1: -> SYNC, tooth_cnt <= 0, gap_pulse; rev_cnt += 1 only if state was SYNC; rev_cnt wraps 0xFFFF -> 0.
REQ-023 CHECK/SYNC, gap with tooth_cnt != TEETH-1: -> CHECK, tooth_cnt <= 0, gap_pulse, err_pulse, sync low (early gap).
REQ-024 sync SHALL be registered, high exactly when state is SYNC.
REQ-025 Latency: state, tooth_cnt, sync, pulses SHALL update on the clock edge ending the cap_valid cycle (1 cycle).
REQ-026 ovf in any state except IDLE: -> FILL, fill count 0, tooth_cnt 0, sync low; err_pulse only if state was SYNC; rev_cnt held.
REQ-027 ovf and cap_valid same cycle: ovf wins, capture ignored.
REQ-028 ena low with ovf or cap_valid same cycle: ena wins.

Reset
REQ-029 rst low SHALL asynchronously set state IDLE, sync 0, tooth_cnt 0, rev_cnt 0, fill count 0, gap_pulse 0, err_pulse 0.
REQ-030 Release of rst SHALL leave state IDLE; no output change until first clk edge with ena high.

Structure
REQ-031 Shared package hwag_pkg SHALL hold the state enum and defaults HWAG_PCAP_W = 24, HWAG_TEETH = 58.
REQ-032 Gap criterion SHALL live in sub-module hwag_gap_cmp (combinational, parameter WIDTH); FSM and counters in hwag_gap_sync.

Verification
REQ-033 Lock: ena=1, 60 teeth at period 1000 then gap 3000, repeat 2 revs -> sync high after 2nd gap, tooth_cnt 0..57, gap_pulse per gap, rev_cnt = 1 after 3rd gap.
REQ-034 Early gap: in SYNC inject gap at tooth_cnt 30 -> err_pulse, sync low, state CHECK, tooth_cnt 0; next correct gap restores sync.
REQ-035 Missing gap: in SYNC send period 1000 at tooth_cnt 57 -> err_pulse, SEARCH, sync low.
REQ-036 Threshold: pcap1=1000, pcap0=1500 -> no gap; pcap0=1501 -> gap; pcap1=0xFFFFFF, pcap0=0xFFFFFF -> no gap (no wrap).
REQ-037 ovf in SYNC coincident with cap_valid -> FILL, err_pulse, sync low, rev_cnt held; rst low mid-revolution -> all outputs 0 same cycle.
REQ-038 rev_cnt preloaded via 65535 revs (or forced) -> next SYNC gap wraps to 0; ena low -> IDLE and counters cleared.
